// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-level round-robin arbiter in front of a UART byte transmitter
//
// Shares one UART TX serializer between N_SRC AXI-Stream byte sources. A granted
// source keeps the transmitter from its first byte through its tlast byte, with an
// optional source-ID header byte in front of each packet and a mid-packet stall
// watchdog that revokes a grant whose owner stops supplying bytes.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   s_tdata      source bytes, source i at [8i+7:8i]
//   s_tvalid     per-source valid
//   s_tlast      per-source end of packet
//   s_tready     per-source ready, at most one bit set (combinational)
//   tx_data      byte to the serializer, valid while tx_start is high
//   tx_start     one-cycle request to the serializer
//   tx_busy      serializer busy
//   grant_valid  a source currently owns the transmitter
//   grant_id     index of the owning source
//   err_timeout  one-cycle pulse when the watchdog revokes a grant
`timescale 1ns/1ps

module uart_tx_arb #(
  parameter int         N_SRC     = 4,
  parameter bit         INSERT_ID = 1'b1,
  parameter logic [7:0] ID_BASE   = 8'hA0,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*N_SRC-1:0]         s_tdata,
  input  logic [N_SRC-1:0]           s_tvalid,
  input  logic [N_SRC-1:0]           s_tlast,
  output logic [N_SRC-1:0]           s_tready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       grant_valid,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       err_timeout
);

  localparam int IW = $clog2(N_SRC);
  // Stall counter only has to hold TIMEOUT-1; the revoke fires on that value.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] STALL_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_ISSUE,
    S_GUARD,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   stall_cnt;
  logic            last_f;
  logic            hdr_done;

  logic [IW-1:0]   pick_id;
  logic            pick_found;
  logic [IW-1:0]   idx;

  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            handshake;

  // Round-robin pick: scan from the farthest candidate back to last_grant+1 so
  // the nearest requester after last_grant is the final (winning) assignment.
  always_comb begin
    pick_id    = last_grant;
    pick_found = 1'b0;
    idx        = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N_SRC);
      if (s_tvalid[idx]) begin
        pick_id    = idx;
        pick_found = 1'b1;
      end
    end
  end

  // Only the granted source is ever looked at; other sources' lines are ignored.
  assign sel_valid = s_tvalid[grant_id];
  assign sel_last  = s_tlast[grant_id];
  assign sel_data  = s_tdata[{grant_id, 3'b000} +: 8];
  assign handshake = (state == S_LOAD) && !tx_busy && sel_valid;

  always_comb begin
    s_tready = '0;
    if (state == S_LOAD && !tx_busy) begin
      s_tready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      last_grant  <= IW'(N_SRC - 1);
      stall_cnt   <= '0;
      last_f      <= 1'b0;
      hdr_done    <= 1'b0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          last_f    <= 1'b0;
          stall_cnt <= '0;
          // Without a header the packet is allowed to end right away.
          hdr_done  <= !INSERT_ID;
          if (pick_found) begin
            grant_id    <= pick_id;
            last_grant  <= pick_id;
            grant_valid <= 1'b1;
            state       <= INSERT_ID ? S_HDR : S_LOAD;
          end
        end
        S_HDR: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= ID_BASE + 8'(grant_id);
            hdr_done <= 1'b1;
            last_f   <= 1'b0;
            state    <= S_GUARD;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            // tx_start is raised here so it is high during the ISSUE cycle.
            tx_data   <= sel_data;
            last_f    <= sel_last;
            tx_start  <= 1'b1;
            stall_cnt <= '0;
            state     <= S_ISSUE;
          end else if (!sel_valid) begin
            if (TIMEOUT != 0 && stall_cnt == STALL_MAX) begin
              // last_grant is left on the revoked source so it ranks last next time.
              err_timeout <= 1'b1;
              grant_valid <= 1'b0;
              stall_cnt   <= '0;
              state       <= S_IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_GUARD;
        end
        S_GUARD: begin
          // Serializer raises busy one cycle after the start; don't trust it yet.
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            if (last_f && hdr_done) begin
              grant_valid <= 1'b0;
              state       <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed scoreboard bench for uart_tx_arb
`timescale 1ns/1ps

module tb_uart_tx_arb;

  localparam int         N         = 4;
  localparam bit         INSERT_ID = 1'b1;
  localparam logic [7:0] ID_BASE   = 8'hA0;
  localparam int         TIMEOUT   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [8*N-1:0]   s_tdata  = '0;
  logic [N-1:0]     s_tvalid = '0;
  logic [N-1:0]     s_tlast  = '0;
  logic [N-1:0]     s_tready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;
  int err_count = 0;
  int busy_cyc = 4;
  int busy_cnt;
  int gl_rd = 0;
  int model_last = N - 1;

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [$];
  int         exp_grants [$];
  int         grant_log [$];

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N_SRC     (N),
    .INSERT_ID (INSERT_ID),
    .ID_BASE   (ID_BASE),
    .TIMEOUT   (TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serializer model: busy rises the cycle after an accepted start, lasts busy_cyc cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start && !tx_busy) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_cyc;
    end else if (tx_busy) begin
      if (busy_cnt <= 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Source BFM: presents queue heads, advances a source after its handshake.
  always begin
    logic [N-1:0] hs;
    logic [8:0]   head;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        head = src_q[i][0];
        s_tvalid[i]      = 1'b1;
        s_tdata[8*i +: 8] = head[7:0];
        s_tlast[i]       = head[8];
      end else begin
        s_tvalid[i]      = 1'b0;
        s_tdata[8*i +: 8] = 8'h00;
        s_tlast[i]       = 1'b0;
      end
    end
  end

  // Output monitor: scoreboard pops and protocol checks.
  always @(negedge clk) begin
    logic prev_start;
    logic prev_gv;
    logic [7:0] e;
    if (rst) begin
      prev_start = 1'b0;
      prev_gv    = 1'b0;
    end else begin
      if (tx_start) begin
        check("start_while_busy", tx_busy, 0);
        check("start_back_to_back", prev_start, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_start", tx_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e);
        end
      end
      if (tx_busy) check("ready_during_busy", s_tready, 0);
      check("ready_onehot", ($countones(s_tready) <= 1), 1);
      if (err_timeout) err_count++;
      if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_id));
      prev_start = tx_start;
      prev_gv    = grant_valid;
    end
  end

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic begin_pkt(input int src);
    exp_grants.push_back(src);
    if (INSERT_ID) exp_q.push_back(8'(int'(ID_BASE) + src));
  endtask

  task automatic add_byte(input int src, input logic [7:0] d, input bit last);
    src_q[src].push_back({last, d});
    exp_q.push_back(d);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (n < budget && !(exp_q.size() == 0 && !grant_valid && !tx_busy && src_empty())) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_count"}, grant_log.size() - gl_rd, exp_grants.size());
    for (int i = 0; i < exp_grants.size() && (gl_rd + i) < grant_log.size(); i++)
      check(tag, grant_log[gl_rd + i], exp_grants[i]);
    gl_rd = grant_log.size();
    exp_grants.delete();
  endtask

  task automatic wait_start_data(input string tag, input logic [7:0] d, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (tx_start && tx_data == d) break;
      n++;
    end
    check(tag, (n < budget), 1);
  endtask

  task automatic wait_busy(input string tag, input logic level, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (tx_busy == level) break;
      n++;
    end
    check(tag, (n < budget), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_grant_valid"}, grant_valid, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    int first;
    int s;
    int k;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2 rst = 1'b0;

    // Single source, two-byte packet, plus one-cycle arbitration latency.
    begin_pkt(0);
    add_byte(0, 8'h55, 1'b0);
    add_byte(0, 8'h3C, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("arb_req_seen", s_tvalid[0], 1);
    check("arb_not_yet", grant_valid, 0);
    @(negedge clk);
    check("arb_granted", grant_valid, 1);
    check("arb_grant_id", grant_id, 0);
    wait_done("single_done", 400);
    check("single_last_byte", tx_data, 8'h3C);
    check_grants("single_grants");
    model_last = 0;

    // Header insertion from source 2.
    begin_pkt(2);
    add_byte(2, 8'h11, 1'b1);
    wait_done("hdr_done", 400);
    check_grants("hdr_grants");
    model_last = 2;

    // Fairness: every source holds two back-to-back 2-byte packets.
    first = (model_last + 1) % N;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < N; j++) begin
        s = (first + j) % N;
        begin_pkt(s);
        add_byte(s, 8'(16 * s + 2 * p), 1'b0);
        add_byte(s, 8'(16 * s + 2 * p + 1), 1'b1);
        model_last = s;
      end
    end
    wait_done("fair_done", 3000);
    check_grants("fair_grants");

    // Slow serializer: 20 busy cycles per byte.
    busy_cyc = 20;
    begin_pkt(3);
    add_byte(3, 8'hB1, 1'b0);
    add_byte(3, 8'hB2, 1'b1);
    wait_done("busy_done", 1000);
    check_grants("busy_grants");
    busy_cyc = 4;
    model_last = 3;

    // Watchdog: source 1 stalls mid-packet, source 2 is waiting.
    begin_pkt(1);
    src_q[1].push_back({1'b0, 8'h01});
    exp_q.push_back(8'h01);
    n = 0;
    while (n < 200 && !grant_valid) begin
      @(negedge clk);
      n++;
    end
    check("wd_grant_seen", grant_valid, 1);
    check("wd_grant_id", grant_id, 1);
    begin_pkt(2);
    add_byte(2, 8'h22, 1'b1);
    wait_start_data("wd_byte_start", 8'h01, 200);
    wait_busy("wd_busy_high", 1'b1, 50);
    wait_busy("wd_busy_low", 1'b0, 50);
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (err_timeout) break;
    end
    check("wd_latency", k, TIMEOUT + 1);
    check("wd_released", grant_valid, 0);
    @(negedge clk);
    check("wd_pulse_width", err_timeout, 0);
    wait_done("wd_done", 400);
    check_grants("wd_grants");
    check("wd_pulse_count", err_count, 1);

    // Reset during DRAIN of a multi-byte packet.
    begin_pkt(0);
    add_byte(0, 8'h71, 1'b0);
    add_byte(0, 8'h72, 1'b0);
    add_byte(0, 8'h73, 1'b1);
    wait_start_data("rst_byte_start", 8'h71, 400);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_grants.delete();
    gl_rd = grant_log.size();
    @(negedge clk);
    check_reset_outputs("midrst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_no_start", tx_start, 0);
    end
    begin_pkt(0);
    add_byte(0, 8'h81, 1'b1);
    begin_pkt(2);
    add_byte(2, 8'h82, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    wait_done("postrst_done", 600);
    check_grants("postrst_grants");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed run still active expected finished");
    $fatal(1, "global timeout");
  end

endmodule
